ysyx_20020207_axi_arbiter: RTL and testbench
============================================

# ysyx_20020207_axi_arbiter

AXI4-Lite arbiter that merges the instruction-fetch unit's read-only port and the load/store unit's read/write port onto the core's single `io_master_*` port. It sits directly downstream of the LSU's `io_master_*` outputs and the IFU fetch port, and upstream of the crossbar/SoC bus. It grants exactly one whole transaction at a time and passes the handshake straight through for the granted requester.

## Interface
Parameters:
- `ADDR_W`, 32, address width of every AR/AW channel.
- `DATA_W`, 32, data width of R/W channels; W strobe width is `DATA_W/8`.

Ports (grouped per channel; all signals in a group share the direction shown; `valid`/`ready` are 1 bit):
- `clk`  in  1  single clock; everything is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ifu_arvalid`, `ifu_araddr`  in  1/ADDR_W  IFU fetch request.
- `ifu_arready`  out  1  IFU fetch address accepted.
- `ifu_rvalid`, `ifu_rresp`, `ifu_rdata`  out  1/2/DATA_W  IFU read response.
- `ifu_rready`  in  1  IFU accepts the response.
- `lsu_arvalid`, `lsu_araddr`  in  1/ADDR_W  LSU load address.
- `lsu_arready`  out  1.
- `lsu_rvalid`, `lsu_rresp`, `lsu_rdata`  out  1/2/DATA_W  LSU load response.
- `lsu_rready`  in  1.
- `lsu_awvalid`, `lsu_awaddr`, `lsu_wvalid`, `lsu_wdata`, `lsu_wstrb`  in  1/ADDR_W/1/DATA_W/DATA_W/8  LSU store address and data.
- `lsu_awready`, `lsu_wready`  out  1/1.
- `lsu_bvalid`, `lsu_bresp`  out  1/2  LSU store response.
- `lsu_bready`  in  1.
- `io_master_ar*`, `io_master_aw*`, `io_master_w*`  out (`*ready` in)  same widths as above  downstream request channels.
- `io_master_r*`, `io_master_b*`  in (`rready`, `bready` out)  same widths  downstream response channels.

## Operation
State machine `state` has four states: IDLE, IFU_RD, LSU_RD and LSU_WR. It is the only sequential state besides the grant bookkeeping.

IDLE:
- All downstream valids are 0.
- All upstream readies and response valids are 0.
- `io_master_rready` and `io_master_bready` are 0.
- Arbitration uses fixed priority, evaluated every IDLE cycle:
  - `lsu_awvalid | lsu_wvalid` → LSU_WR;
  - else `lsu_arvalid` → LSU_RD;
  - else `ifu_arvalid` → IFU_RD;
  - else stay in IDLE.

IFU_RD / LSU_RD:
- The granted requester's AR and R signals are wired combinationally to `io_master_ar*` and `io_master_r*`.
- The non-granted requester sees `arready=0` and `rvalid=0`.
- An `arvalid` held by a non-granted requester stays pending; it is neither dropped nor acknowledged.
- Transition: on `io_master_rvalid & io_master_rready` (the requester's rready is forwarded), go to IDLE.

LSU_WR:
- AW, W and B are passed through combinationally.
- AW and W complete independently, in either order or in the same cycle.
- Transition: on `io_master_bvalid & io_master_bready`, go to IDLE.

General rules:
- A multi-beat split access from the LSU (second beat at addr+4) is two separate transactions. The LSU re-arbitrates for the second beat, and LSU priority guarantees it is not starved by the IFU.
- `rresp`/`bresp` pass through unmodified, including SLVERR/DECERR. The arbiter does not act on them.
- A downstream `rvalid`/`bvalid` arriving in a state that does not own that channel is not acknowledged (ready=0). The slave holds it; this is a protocol violation for verification to flag.

## Timing
- Reset: `state`=IDLE immediately (asynchronous). Every output is 0 while `rst` is high and in the first cycle after release.
- Grant latency: a request visible in IDLE at edge N is granted at N; the downstream valid asserts in cycle N+1. One bubble per transaction.
- Release: the completing response handshake at edge M sets IDLE. The next grant is at M+1, so back-to-back transactions have a 2-cycle minimum spacing.
- No registered datapath: addresses, data, strobes and responses have zero added latency once granted.
- Simultaneous requests: both LSU read and LSU write pending → write first. LSU plus IFU pending → LSU first. No round-robin.
- Reset asserted mid-transaction: forwarding stops immediately and the outstanding downstream transaction is abandoned. Bus reset is assumed common.
- `io_master_araddr` and `io_master_awaddr` must be stable while their valid is high. This is the requester's obligation; the arbiter only gates.

## Test plan
- IFU-only fetch: `ifu_arvalid`, addr 0x8000_0000; slave replies after 3 cycles with data 0x0000_0413, resp 0 → `io_master_arvalid` in cycle 1 after request; `ifu_rdata`=0x0000_0413; state returns to IDLE one cycle after the R handshake.
- Contention: `ifu_arvalid` and `lsu_arvalid` asserted on the same edge (0x8000_0000 / 0x8000_1000) → LSU read is issued first. The IFU AR is presented 2 cycles after the LSU R handshake. `ifu_arready` stays 0 throughout the LSU transaction.
- LSU store, W before AW: `wvalid` accepted at cycle 1, `awvalid` at cycle 3, addr 0x8000_0004, wstrb 0b0011 → exactly one B response is routed to `lsu_bvalid`, then IDLE. No IFU grant occurs before B.
- Split store: two consecutive LSU writes to 0x8000_0003 (wstrb 0b1000) and 0x8000_0004 (wstrb 0b0111) with `ifu_arvalid` continuously high → both writes complete before the IFU is granted.
- Error pass-through: slave returns `rresp`=2'b10 on an LSU load → `lsu_rresp`=2'b10 and `ifu_rvalid` stays 0.
- Async reset at cycle 2 of an LSU_RD → `io_master_arvalid` and `lsu_arready` drop within the same cycle. After release, a new IFU request is granted normally.

Source files
------------

// File: rtl/ysyx_20020207_axi_arbiter.sv
// ysyx_20020207_axi_arbiter: grants one whole AXI4-Lite transaction at a time
// between the IFU read port and the LSU read/write port onto io_master_*.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ifu_ar*/ifu_r*      IFU fetch address and read response
//   lsu_ar*/lsu_r*      LSU load address and read response
//   lsu_aw*/lsu_w*/lsu_b* LSU store address, data and write response
//   io_master_*         single downstream AXI4-Lite master port
module ysyx_20020207_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_arvalid,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    output logic                ifu_arready,
    output logic                ifu_rvalid,
    output logic [1:0]          ifu_rresp,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                ifu_rready,
    input  logic                lsu_arvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    output logic                lsu_arready,
    output logic                lsu_rvalid,
    output logic [1:0]          lsu_rresp,
    output logic [DATA_W-1:0]   lsu_rdata,
    input  logic                lsu_rready,
    input  logic                lsu_awvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_wvalid,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_awready,
    output logic                lsu_wready,
    output logic                lsu_bvalid,
    output logic [1:0]          lsu_bresp,
    input  logic                lsu_bready,
    output logic                io_master_arvalid,
    output logic [ADDR_W-1:0]   io_master_araddr,
    input  logic                io_master_arready,
    input  logic                io_master_rvalid,
    input  logic [1:0]          io_master_rresp,
    input  logic [DATA_W-1:0]   io_master_rdata,
    output logic                io_master_rready,
    output logic                io_master_awvalid,
    output logic [ADDR_W-1:0]   io_master_awaddr,
    input  logic                io_master_awready,
    output logic                io_master_wvalid,
    output logic [DATA_W-1:0]   io_master_wdata,
    output logic [DATA_W/8-1:0] io_master_wstrb,
    input  logic                io_master_wready,
    input  logic                io_master_bvalid,
    input  logic [1:0]          io_master_bresp,
    output logic                io_master_bready
);
    typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;
    state_t state, state_nxt;
    logic g_ifu, g_lrd, g_wr;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    // Fixed priority: LSU store, then LSU load, then IFU fetch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:           state_nxt = (lsu_awvalid | lsu_wvalid) ? LSU_WR :
                                        lsu_arvalid ? LSU_RD : ifu_arvalid ? IFU_RD : IDLE;
            IFU_RD, LSU_RD: state_nxt = (io_master_rvalid & io_master_rready) ? IDLE : state;
            LSU_WR:         state_nxt = (io_master_bvalid & io_master_bready) ? IDLE : state;
            default:        state_nxt = IDLE;
        endcase
    end

    assign g_ifu = state == IFU_RD;
    assign g_lrd = state == LSU_RD;
    assign g_wr  = state == LSU_WR;

    assign io_master_arvalid = g_ifu ? ifu_arvalid : g_lrd & lsu_arvalid;
    assign io_master_araddr  = g_ifu ? ifu_araddr : g_lrd ? lsu_araddr : '0;
    assign io_master_rready  = g_ifu ? ifu_rready : g_lrd & lsu_rready;

    assign ifu_arready = g_ifu & io_master_arready;
    assign ifu_rvalid  = g_ifu & io_master_rvalid;
    assign ifu_rresp   = g_ifu ? io_master_rresp : '0;
    assign ifu_rdata   = g_ifu ? io_master_rdata : '0;

    assign lsu_arready = g_lrd & io_master_arready;
    assign lsu_rvalid  = g_lrd & io_master_rvalid;
    assign lsu_rresp   = g_lrd ? io_master_rresp : '0;
    assign lsu_rdata   = g_lrd ? io_master_rdata : '0;

    assign io_master_awvalid = g_wr & lsu_awvalid;
    assign io_master_awaddr  = g_wr ? lsu_awaddr : '0;
    assign io_master_wvalid  = g_wr & lsu_wvalid;
    assign io_master_wdata   = g_wr ? lsu_wdata : '0;
    assign io_master_wstrb   = g_wr ? lsu_wstrb : '0;
    assign io_master_bready  = g_wr & lsu_bready;

    assign lsu_awready = g_wr & io_master_awready;
    assign lsu_wready  = g_wr & io_master_wready;
    assign lsu_bvalid  = g_wr & io_master_bvalid;
    assign lsu_bresp   = g_wr ? io_master_bresp : '0;
endmodule

// File: tb/tb_ysyx_20020207_axi_arbiter.sv
// tb_ysyx_20020207_axi_arbiter: randomized bench against a transaction-owner reference model.
module tb_ysyx_20020207_axi_arbiter;
    logic        clk = 1'b0, rst;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_awvalid, lsu_wvalid, lsu_awready, lsu_wready, lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic [1:0]  lsu_bresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_araddr, m_rdata;
    logic [1:0]  m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp;

    int n_cmp = 0, n_err = 0;
    int owner = 0;  // 0 nobody, 1 IFU read, 2 LSU read, 3 LSU write
    int rst_hold = 0;
    bit rst_done = 0;
    int grants[4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    ysyx_20020207_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
        .lsu_rvalid(lsu_rvalid), .lsu_rresp(lsu_rresp), .lsu_rdata(lsu_rdata), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_wvalid(lsu_wvalid),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_awready(lsu_awready),
        .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
        .io_master_arvalid(m_arvalid), .io_master_araddr(m_araddr), .io_master_arready(m_arready),
        .io_master_rvalid(m_rvalid), .io_master_rresp(m_rresp), .io_master_rdata(m_rdata),
        .io_master_rready(m_rready), .io_master_awvalid(m_awvalid), .io_master_awaddr(m_awaddr),
        .io_master_awready(m_awready), .io_master_wvalid(m_wvalid), .io_master_wdata(m_wdata),
        .io_master_wstrb(m_wstrb), .io_master_wready(m_wready), .io_master_bvalid(m_bvalid),
        .io_master_bresp(m_bresp), .io_master_bready(m_bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_rand();
        ifu_arvalid = ($urandom % 3) == 0;
        ifu_araddr  = $urandom;
        ifu_rready  = $urandom % 2;
        lsu_arvalid = ($urandom % 5) == 0;
        lsu_araddr  = $urandom;
        lsu_rready  = $urandom % 2;
        lsu_awvalid = ($urandom % 8) == 0;
        lsu_awaddr  = $urandom;
        lsu_wvalid  = ($urandom % 8) == 0;
        lsu_wdata   = $urandom;
        lsu_wstrb   = 4'($urandom);
        lsu_bready  = $urandom % 2;
        m_arready   = $urandom % 2;
        m_rvalid    = ($urandom % 3) == 0;
        m_rresp     = 2'($urandom);
        m_rdata     = $urandom;
        m_awready   = $urandom % 2;
        m_wready    = $urandom % 2;
        m_bvalid    = ($urandom % 3) == 0;
        m_bresp     = 2'($urandom);
    endtask

    // The owner of the bus sees the downstream port as if directly connected;
    // everyone else sees idle handshakes.
    task automatic check_outputs();
        bit fi, fl, fw;
        logic [11:0] exp_ctrl;
        fi = owner == 1;
        fl = owner == 2;
        fw = owner == 3;
        exp_ctrl = {(fi && ifu_arvalid) || (fl && lsu_arvalid),
                    (fi && ifu_rready) || (fl && lsu_rready),
                    fw && lsu_awvalid, fw && lsu_wvalid, fw && lsu_bready,
                    fi && m_arready, fi && m_rvalid,
                    fl && m_arready, fl && m_rvalid,
                    fw && m_awready, fw && m_wready, fw && m_bvalid};
        chk("ctrl", 64'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                         ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid,
                         lsu_awready, lsu_wready, lsu_bvalid}), 64'(exp_ctrl));
        if (fi) chk("ifu_araddr", 64'(m_araddr), 64'(ifu_araddr));
        if (fl) chk("lsu_araddr", 64'(m_araddr), 64'(lsu_araddr));
        if (fi) chk("ifu_r", 64'({ifu_rresp, ifu_rdata}), 64'({m_rresp, m_rdata}));
        if (fl) chk("lsu_r", 64'({lsu_rresp, lsu_rdata}), 64'({m_rresp, m_rdata}));
        if (fw) chk("awaddr", 64'(m_awaddr), 64'(lsu_awaddr));
        if (fw) chk("wdata", 64'({m_wstrb, m_wdata}), 64'({lsu_wstrb, lsu_wdata}));
        if (fw) chk("bresp", 64'(lsu_bresp), 64'(m_bresp));
    endtask

    task automatic model_step();
        if (rst) owner = 0;
        else if (owner == 0) begin
            owner = (lsu_awvalid || lsu_wvalid) ? 3 : lsu_arvalid ? 2 : ifu_arvalid ? 1 : 0;
            grants[owner]++;
        end
        else if (owner == 1 && m_rvalid && ifu_rready) owner = 0;
        else if (owner == 2 && m_rvalid && lsu_rready) owner = 0;
        else if (owner == 3 && m_bvalid && lsu_bready) owner = 0;
    endtask

    initial begin
        rst = 1'b1;
        drive_rand();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_rand();
            #1 check_outputs();
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i > 0) @(negedge clk);
            if (rst) begin
                if (rst_hold == 0) rst = 1'b0;
                else rst_hold--;
            end
            else if (!rst_done && i >= 2000 && owner != 0) begin
                rst = 1'b1;
                owner = 0;
                rst_done = 1;
                rst_hold = 1;
            end
            drive_rand();
            #1 check_outputs();
            @(posedge clk);
            model_step();
        end
        chk("reset_injected", 64'(rst_done), 64'd1);
        chk("ifu_grants_seen", 64'(grants[1] > 10), 64'd1);
        chk("lsu_rd_grants_seen", 64'(grants[2] > 10), 64'd1);
        chk("lsu_wr_grants_seen", 64'(grants[3] > 10), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
